// File: rtl/uart_word_display_pkg.sv
// Shared types and constants for the UART word display: display modes and
// active-low seven-segment codes (segment order a..g, seg[6]=a).
package uart_word_display_pkg;

    typedef enum logic [1:0] {
        MODE_EMPTY = 2'd0,
        MODE_SHOW  = 2'd1,
        MODE_ERROR = 2'd2
    } mode_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_E     = 7'b0110000;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

// File: rtl/uart_word_display_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
    import uart_word_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = HEX_SEG[nibble];
    end

endmodule

// File: rtl/uart_word_display.sv
// Assembles received bytes MSB-first into a word and shows it on a scanned,
// active-low seven-segment display with error mode and partial-word timeout.
module uart_word_display
    import uart_word_display_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                Rx_DATA,
    input  logic                      Rx_VALID,
    input  logic                      Rx_FERROR,
    input  logic                      Rx_PERROR,
    output logic [4*NUM_DIGITS-1:0]   word_out,
    output logic                      word_valid,
    output logic                      err_flag,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                seg
);

    localparam int W     = 4 * NUM_DIGITS;
    localparam int BYTES = NUM_DIGITS / 2;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [W-1:0]            shadow_q, shadow_d;
    logic [CNT_W-1:0]        byte_cnt_q, byte_cnt_d;
    logic [TO_W-1:0]         timeout_q, timeout_d;
    logic [W-1:0]            word_q, word_d;
    logic                    word_valid_q, word_valid_d;
    mode_e                   mode_q, mode_d;
    logic [REF_W-1:0]        refresh_q, refresh_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;

    logic                    err_ev, good_ev;
    logic [W+7:0]            shifted;
    logic [W-1:0]            assembled;
    logic [3:0]              nibble;
    logic [6:0]              hex_seg;

    hex_to_seg7 u_hex (
        .nibble (nibble),
        .seg    (hex_seg)
    );

    // Byte assembly, error handling and partial-word timeout
    always_comb begin
        err_ev       = Rx_FERROR || Rx_PERROR;
        good_ev      = Rx_VALID && !err_ev;
        shifted      = {shadow_q, Rx_DATA};
        assembled    = shifted[W-1:0];
        shadow_d     = shadow_q;
        byte_cnt_d   = byte_cnt_q;
        timeout_d    = timeout_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        mode_d       = mode_q;
        if (err_ev) begin
            byte_cnt_d = '0;
            timeout_d  = '0;
            mode_d     = MODE_ERROR;
        end else if (good_ev) begin
            timeout_d = '0;
            shadow_d  = assembled;
            if (byte_cnt_q == CNT_W'(BYTES - 1)) begin
                word_d       = assembled;
                word_valid_d = 1'b1;
                byte_cnt_d   = '0;
                mode_d       = MODE_SHOW;
            end else begin
                byte_cnt_d = byte_cnt_q + 1'b1;
            end
        end else if (byte_cnt_q != '0) begin
            if (timeout_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                byte_cnt_d = '0;
                timeout_d  = '0;
            end else begin
                timeout_d = timeout_q + 1'b1;
            end
        end
    end

    // Scan: an/seg are computed for the next slot position so both registers
    // always describe the same digit and count-0 blanking lines up exactly.
    always_comb begin
        refresh_d = refresh_q + 1'b1;
        idx_d     = idx_q;
        if (refresh_q == REF_W'(REFRESH_DIV - 1)) begin
            refresh_d = '0;
            idx_d     = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        an_d = (refresh_d == '0) ? '1 : ~(NUM_DIGITS'(1) << idx_d);
        nibble = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) nibble = word_q[4*i +: 4];
        end
        case (mode_q)
            MODE_SHOW:  seg_d = hex_seg;
            MODE_ERROR: seg_d = (idx_d == IDX_W'(NUM_DIGITS - 1)) ? SEG_E : SEG_DASH;
            default:    seg_d = SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q     <= '0;
            byte_cnt_q   <= '0;
            timeout_q    <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            mode_q       <= MODE_EMPTY;
            refresh_q    <= '0;
            idx_q        <= '0;
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
        end else begin
            shadow_q     <= shadow_d;
            byte_cnt_q   <= byte_cnt_d;
            timeout_q    <= timeout_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            mode_q       <= mode_d;
            refresh_q    <= refresh_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = word_valid_q;
    assign err_flag   = (mode_q == MODE_ERROR);
    assign an         = an_q;
    assign seg        = seg_q;

endmodule

// File: tb/tb_uart_word_display.sv
// Directed bench for uart_word_display: a 4-digit and a 6-digit instance,
// committed words checked against a scoreboard queue on every word_valid.
module tb_uart_word_display;

    logic        clk = 1'b0;
    logic        reset, rst6;
    logic [7:0]  rx_data, rx6_data;
    logic        rx_valid, rx_ferr, rx_perr, rx6_valid;
    logic        zero6 = 1'b0;

    logic [15:0] word4;
    logic        wv4, err4;
    logic [3:0]  an4;
    logic [6:0]  seg4;

    logic [23:0] word6;
    logic        wv6, err6;
    logic [5:0]  an6;
    logic [6:0]  seg6;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] q4[$];
    logic [23:0] q6[$];

    always #5 clk = ~clk;

    uart_word_display #(.NUM_DIGITS(4), .REFRESH_DIV(8), .TIMEOUT_CYCLES(20)) dut4 (
        .clk(clk), .reset(reset), .Rx_DATA(rx_data), .Rx_VALID(rx_valid),
        .Rx_FERROR(rx_ferr), .Rx_PERROR(rx_perr), .word_out(word4),
        .word_valid(wv4), .err_flag(err4), .an(an4), .seg(seg4)
    );

    uart_word_display #(.NUM_DIGITS(6), .REFRESH_DIV(4), .TIMEOUT_CYCLES(1000)) dut6 (
        .clk(clk), .reset(rst6), .Rx_DATA(rx6_data), .Rx_VALID(rx6_valid),
        .Rx_FERROR(zero6), .Rx_PERROR(zero6), .word_out(word6),
        .word_valid(wv6), .err_flag(err6), .an(an6), .seg(seg6)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        if (!reset && wv4) begin
            check("sb4_expected", 32'(q4.size() > 0), 32'd1);
            if (q4.size() > 0) check("sb4_word", 32'(word4), 32'(q4.pop_front()));
        end
        if (!rst6 && wv6) begin
            check("sb6_expected", 32'(q6.size() > 0), 32'd1);
            if (q6.size() > 0) check("sb6_word", 32'(word6), 32'(q6.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send4(input logic [7:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send6(input logic [7:0] d);
        rx6_data  = d;
        rx6_valid = 1'b1;
        tick();
        rx6_valid = 1'b0;
    endtask

    task automatic wait_an4(input logic [3:0] tgt);
        int n = 0;
        while (an4 !== tgt && n < 40) begin
            tick();
            n++;
        end
        check("an4_wait", 32'(an4), 32'(tgt));
    endtask

    initial begin
        logic [3:0] exp_an4;
        logic [5:0] exp_an6;
        reset = 1'b1; rst6 = 1'b1;
        rx_data = '0; rx_valid = 0; rx_ferr = 0; rx_perr = 0;
        rx6_data = '0; rx6_valid = 0;
        repeat (3) tick();
        reset = 1'b0; rst6 = 1'b0;

        check("rst_word4", 32'(word4), 32'h0);
        check("rst_wv4", 32'(wv4), 32'h0);
        check("rst_err4", 32'(err4), 32'h0);

        // Scan pattern while EMPTY: c counts edges since reset release
        for (int c = 0; c < 34; c++) begin
            exp_an4 = (c % 8 == 0) ? 4'hF : ~(4'b1 << ((c / 8) % 4));
            exp_an6 = (c % 4 == 0) ? 6'h3F : ~(6'b1 << ((c / 4) % 6));
            check("scan_an4", 32'(an4), 32'(exp_an4));
            check("scan_seg4", 32'(seg4), 32'h7F);
            check("scan_an6", 32'(an6), 32'(exp_an6));
            tick();
        end

        // Word DA8A
        q4.push_back(16'hDA8A);
        send4(8'hDA);
        check("wv_early", 32'(wv4), 32'h0);
        send4(8'h8A);
        check("wv_pulse", 32'(wv4), 32'h1);
        check("word_DA8A", 32'(word4), 32'hDA8A);
        tick();
        check("wv_single", 32'(wv4), 32'h0);
        wait_an4(4'b0111);
        check("seg_d3", 32'(seg4), 32'b1000010);
        wait_an4(4'b1110);
        check("seg_a0", 32'(seg4), 32'b0001000);

        // Error mid-word
        send4(8'h12);
        rx_ferr = 1'b1;
        tick();
        rx_ferr = 1'b0;
        check("err_set", 32'(err4), 32'h1);
        check("err_word_kept", 32'(word4), 32'hDA8A);
        wait_an4(4'b0111);
        check("seg_err_E", 32'(seg4), 32'b0110000);
        wait_an4(4'b1011);
        check("seg_err_dash2", 32'(seg4), 32'b1111110);
        wait_an4(4'b1110);
        check("seg_err_dash0", 32'(seg4), 32'b1111110);
        q4.push_back(16'h3456);
        send4(8'h34);
        send4(8'h56);
        check("word_3456", 32'(word4), 32'h3456);
        check("err_clear", 32'(err4), 32'h0);

        // Timeout discards a stale byte; a short gap does not
        send4(8'hAB);
        repeat (25) tick();
        q4.push_back(16'hCDEF);
        send4(8'hCD);
        send4(8'hEF);
        check("word_CDEF", 32'(word4), 32'hCDEF);
        check("to_err_kept", 32'(err4), 32'h0);
        send4(8'h12);
        repeat (10) tick();
        q4.push_back(16'h1234);
        send4(8'h34);
        check("word_1234", 32'(word4), 32'h1234);

        // Valid with parity error in the same cycle is an error
        rx_perr = 1'b1;
        send4(8'h11);
        rx_perr = 1'b0;
        check("perr_flag", 32'(err4), 32'h1);
        check("perr_no_wv", 32'(wv4), 32'h0);
        q4.push_back(16'h2233);
        send4(8'h22);
        send4(8'h33);
        check("word_2233", 32'(word4), 32'h2233);

        // Six-digit instance: assembly, mid-word reset
        q6.push_back(24'h012345);
        send6(8'h01);
        send6(8'h23);
        send6(8'h45);
        check("word_012345", 32'(word6), 32'h012345);
        send6(8'h67);
        rst6 = 1'b1;
        tick();
        rst6 = 1'b0;
        check("rst6_word", 32'(word6), 32'h0);
        check("rst6_wv", 32'(wv6), 32'h0);
        check("rst6_err", 32'(err6), 32'h0);
        check("rst6_an", 32'(an6), 32'h3F);
        check("rst6_seg", 32'(seg6), 32'h7F);
        q6.push_back(24'h89ABCD);
        send6(8'h89);
        send6(8'hAB);
        send6(8'hCD);
        check("word_89ABCD", 32'(word6), 32'h89ABCD);

        tick();
        check("sb4_drained", 32'(q4.size()), 32'h0);
        check("sb6_drained", 32'(q6.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/uart_word_display.md
Name: uart_word_display

Overview:
- Receive-side display stage placed after the UART receiver.
- Collects BYTES = NUM_DIGITS/2 received bytes into one word and latches the complete word.
- Drives a time-multiplexed, active-low seven-segment display with any even number of digits.
- Adds three modes the fixed 4-digit display path lacks: partial-word timeout, error display mode and anti-ghost blanking.

Parameters:
NUM_DIGITS, 4, number of hex digits; must be even and >= 2; word width W = 4*NUM_DIGITS.
REFRESH_DIV, 50000, clock cycles per digit slot (1 ms at 50 MHz).
TIMEOUT_CYCLES, 500000, idle cycles after which a partial word is discarded.

Ports:
clk  input  1  system clock, 50 MHz.
reset  input  1  synchronous, active-high reset.
Rx_DATA  input  8  received byte, valid only while Rx_VALID is high.
Rx_VALID  input  1  one-cycle pulse: good byte available.
Rx_FERROR  input  1  one-cycle pulse: framing error on the current byte.
Rx_PERROR  input  1  one-cycle pulse: parity error on the current byte.
word_out  output  W  last complete word.
word_valid  output  1  one-cycle pulse when word_out updates.
err_flag  output  1  high while the display is in ERROR mode.
an  output  NUM_DIGITS  digit enables, active-low; bit 0 = rightmost digit.
seg  output  7  segments a..g, seg[6]=a … seg[0]=g, active-low.

Behaviour:
- Reset (synchronous, active-high) values:
  - word_out = 0, word_valid = 0, err_flag = 0.
  - an = all 1s, seg = 7'b1111111.
  - Byte counter, shadow register, timeout counter, refresh counter and digit index = 0.
  - Display mode = EMPTY.
- Byte events, one per cycle:
  - Error event: Rx_FERROR or Rx_PERROR high. Takes priority if asserted in the same cycle as Rx_VALID.
  - Good event: Rx_VALID high with no error flag.
- Assembly, MSB first:
  - On a good event: shadow <= {shadow[W-9:0], Rx_DATA}; byte_cnt increments.
  - If this is byte BYTES-1: the next cycle word_out = the full assembled word, word_valid pulses for exactly 1 cycle, byte_cnt returns to 0 and mode becomes SHOW.
  - Latency: word_out and word_valid appear 1 cycle after the final Rx_VALID.
- Error event:
  - Discard the partial word (byte_cnt = 0). word_out keeps its previous value.
  - Mode becomes ERROR; err_flag goes high the next cycle.
  - ERROR is left only when a complete good word is committed; err_flag then clears in the same cycle word_valid pulses.
- Timeout:
  - The counter runs only while byte_cnt != 0 and restarts at 0 on every good event.
  - When it reaches TIMEOUT_CYCLES-1: byte_cnt = 0 and the partial word is dropped. Mode, word_out and err_flag are unchanged.
  - A good event in the expiry cycle wins: the byte is accepted and the counter restarts.
- Display mode FSM:
  - EMPTY -> SHOW on word commit; EMPTY -> ERROR on error event.
  - SHOW -> ERROR on error event.
  - ERROR -> SHOW on word commit.
- Scan:
  - The refresh counter wraps at REFRESH_DIV-1; on wrap the digit index increments modulo NUM_DIGITS (wrap from NUM_DIGITS-1 to 0).
  - In refresh-count 0 of every slot, an = all 1s (blanking).
  - Otherwise an = ~(1 << index). The digit index does not reset on word commit.
- Segments for digit i:
  - EMPTY: 7'b1111111.
  - SHOW: hex decode of word_out[4i+3:4i].
  - ERROR: leftmost digit shows 'E' (7'b0110000); all other digits show a dash (7'b1111110).
- seg and an are registered together, so they always refer to the same slot.
- Hex codes (active-low, order a..g):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- Reset mid-word or mid-scan clears everything to the reset values above in the next cycle. No partial state survives.

Decomposition:
- Shared package/header:
  - 16-entry hex segment table.
  - Constants SEG_BLANK, SEG_DASH, SEG_E.
  - Mode encodings: EMPTY=2'd0, SHOW=2'd1, ERROR=2'd2.
- One sub-module, hex_to_seg7: 4-bit nibble -> 7-bit active-low segments, purely combinational, instantiated once on the selected nibble.

Test Plan:
- Reset, then run with REFRESH_DIV=8 and NUM_DIGITS=4 -> an stays 1111 for cycle 0 of each slot, then cycles through 1110, 1101, 1011, 0111; seg=1111111 throughout (EMPTY).
- Pulse Rx_VALID with 0xDA, then 0x8A -> 1 cycle after the second pulse: word_out=16'hDA8A and word_valid high for exactly 1 cycle. Digit 3 seg=1000010 (d); digit 0 seg=0001000 (A).
- Send 0x12, then pulse Rx_FERROR -> word_out unchanged and err_flag=1. Digit 3 shows 0110000 and digits 2..0 show 1111110. Then send 0x34, 0x56 -> word_out=16'h3456 and err_flag=0.
- With TIMEOUT_CYCLES=20, send 0xAB and wait 25 cycles, then send 0xCD, 0xEF -> word_out=16'hCDEF (0xAB discarded).
- Assert Rx_VALID (0x11) and Rx_PERROR in the same cycle -> treated as an error: byte dropped, err_flag=1.
- NUM_DIGITS=6: send 0x01, 0x23, 0x45 -> word_out=24'h012345; 6 anode slots scanned; reset asserted mid-word -> all outputs return to reset values.
